// File: rtl/col_gen_sched.sv
// Column-job scheduler: arbitrates two sample sources, buffers an 8-sample job,
// streams it to the column assembler and holds the captured columns for the consumer.
module col_gen_sched #(
  parameter int unsigned TMO = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  s_valid,
  output logic [1:0]  s_ready,
  input  logic [15:0] s0_re,
  input  logic [15:0] s0_im,
  input  logic [15:0] s1_re,
  input  logic [15:0] s1_im,
  output logic        start,
  output logic [15:0] sdr,
  output logic [15:0] sdi,
  input  logic        finish,
  input  logic [63:0] a_col0_r,
  input  logic [63:0] a_col0_i,
  input  logic [63:0] a_col1_r,
  input  logic [63:0] a_col1_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_id,
  output logic [63:0] col0_r,
  output logic [63:0] col0_i,
  output logic [63:0] col1_r,
  output logic [63:0] col1_i,
  output logic        err
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 64;
  localparam int unsigned NS = 8;
  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, STREAM, WAIT, OUT} state_t;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } smp_t;

  typedef struct packed {
    logic [CW-1:0] c0r;
    logic [CW-1:0] c0i;
    logic [CW-1:0] c1r;
    logic [CW-1:0] c1i;
  } cols_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        s_ready_q, s_ready_d;
  logic              start_q, start_d;
  logic [DW-1:0]     sdr_q, sdr_d;
  logic [DW-1:0]     sdi_q, sdi_d;
  logic              out_valid_q, out_valid_d;
  logic              out_id_q, out_id_d;
  cols_t             cols_q, cols_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  smp_t [NS-1:0]     buf_q, buf_d;

  smp_t              sel_c;
  logic              accept_c;

  // Next-state and datapath logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    gnt_d       = gnt_q;
    s_ready_d   = s_ready_q;
    start_d     = 1'b0;
    sdr_d       = '0;
    sdi_d       = '0;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    cols_d      = cols_q;
    err_d       = err_q;
    last_d      = last_q;
    buf_d       = buf_q;
    sel_c       = gnt_q[1] ? {s1_re, s1_im} : {s0_re, s0_im};
    accept_c    = |(s_valid & s_ready_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          // On contention the requester not served last wins
          if (req == 2'b11) gnt_d = last_q ? 2'b01 : 2'b10;
          else              gnt_d = req;
          s_ready_d = gnt_d;
          cnt_d     = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (accept_c) begin
          buf_d[cnt_q] = sel_c;
          cnt_d        = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            s_ready_d = '0;
            start_d   = 1'b1;
            state_d   = START;
          end
        end
      end
      START: begin
        sdr_d   = buf_q[0].re;
        sdi_d   = buf_q[0].im;
        cnt_d   = 3'd1;
        state_d = STREAM;
      end
      STREAM: begin
        // cnt wraps to 0 once slot 7 is on the bus
        if (cnt_q != 3'd0) begin
          sdr_d = buf_q[cnt_q].re;
          sdi_d = buf_q[cnt_q].im;
          cnt_d = cnt_q + 3'd1;
        end else begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (finish) begin
          cols_d      = {a_col0_r, a_col0_i, a_col1_r, a_col1_i};
          out_id_d    = gnt_q[1];
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else if (tmo_q == TW'(TMO - 1)) begin
          err_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          last_d      = gnt_q[1];
          gnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      gnt_q       <= '0;
      s_ready_q   <= '0;
      start_q     <= 1'b0;
      sdr_q       <= '0;
      sdi_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      cols_q      <= '0;
      err_q       <= 1'b0;
      last_q      <= 1'b1;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      gnt_q       <= gnt_d;
      s_ready_q   <= s_ready_d;
      start_q     <= start_d;
      sdr_q       <= sdr_d;
      sdi_q       <= sdi_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      cols_q      <= cols_d;
      err_q       <= err_d;
      last_q      <= last_d;
      buf_q       <= buf_d;
    end
  end

  assign gnt       = gnt_q;
  assign s_ready   = s_ready_q;
  assign start     = start_q;
  assign sdr       = sdr_q;
  assign sdi       = sdi_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign col0_r    = cols_q.c0r;
  assign col0_i    = cols_q.c0i;
  assign col1_r    = cols_q.c1r;
  assign col1_i    = cols_q.c1i;
  assign err       = err_q;

endmodule

// File: tb/tb_col_gen_sched.sv
// Scoreboard bench for col_gen_sched: a driver acts as requesters and assembler,
// monitors check the sample stream and the held results against queued expectations.
module tb_col_gen_sched;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, gnt, s_valid, s_ready;
  logic [15:0] s0_re, s0_im, s1_re, s1_im, sdr, sdi;
  logic        start, finish, out_valid, out_ready, out_id, err;
  logic [63:0] a_col0_r, a_col0_i, a_col1_r, a_col1_i;
  logic [63:0] col0_r, col0_i, col1_r, col1_i;

  col_gen_sched #(.TMO(TMO)) dut (
    .clk(clk), .rst(rst_n), .req(req), .gnt(gnt), .s_valid(s_valid), .s_ready(s_ready),
    .s0_re(s0_re), .s0_im(s0_im), .s1_re(s1_re), .s1_im(s1_im),
    .start(start), .sdr(sdr), .sdi(sdi), .finish(finish),
    .a_col0_r(a_col0_r), .a_col0_i(a_col0_i), .a_col1_r(a_col1_r), .a_col1_i(a_col1_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .col0_r(col0_r), .col0_i(col0_i), .col1_r(col1_r), .col1_i(col1_i), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [63:0] c0r, c0i, c1r, c1i;
    logic        err;
    int          cyc;
  } res_t;

  res_t        exp_out[$];
  logic [31:0] exp_stream[$];
  int          total = 0;
  int          bad = 0;
  int          last_acc = 0;
  int          bp_cycles = 0;
  logic        rr_last = 1'b1;
  logic        p_id = 1'b0;
  logic        p_err = 1'b0;
  logic        m_err = 1'b0;
  logic [63:0] p_c0r = '0, p_c0i = '0, p_c1r = '0, p_c1i = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event, required one (cycle %0d)", name, cyc);
  endtask

  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(negedge clk);
    finish   = 1'b0;
    a_col0_r = {$urandom, $urandom};
    a_col0_i = {$urandom, $urandom};
    a_col1_r = {$urandom, $urandom};
    a_col1_i = {$urandom, $urandom};
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic check_reset_outputs();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_start", 64'(start), 64'(0));
    chk("rst_sd", 64'({sdr, sdi}), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_id", 64'(out_id), 64'(0));
    chk("rst_col0", col0_r | col0_i, 64'(0));
    chk("rst_col1", col1_r | col1_i, 64'(0));
    chk("rst_err", 64'(err), 64'(0));
  endtask

  // Asserts reset away from both clock edges and resets the reference model
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    exp_stream.delete();
    exp_out.delete();
    rr_last = 1'b1;
    p_id = 1'b0; p_err = 1'b0; m_err = 1'b0;
    p_c0r = '0; p_c0i = '0; p_c1r = '0; p_c1i = '0;
    req = '0; s_valid = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  // fd: finish delay into WAIT (<0 = never); rst_at: cycles after last accept to reset (0 = no)
  task automatic run_job(input logic [1:0] rq, input int gmode, input int fd, input int bp,
                         input bit fixed, input int rst_at);
    logic        id;
    logic [31:0] smp [8];
    int          k, budget;
    bit          v;
    res_t        r;
    logic [63:0] c [4];
    id = (rq == 2'b11) ? ~rr_last : rq[1];
    for (int i = 0; i < 8; i++) begin
      smp[i] = fixed ? {16'(i + 1), 16'(i + 1 + 256)} : $urandom;
      exp_stream.push_back(smp[i]);
    end
    bp_cycles = bp;
    req = rq;
    tick();
    chk("gnt", 64'(gnt), 64'(onehot(id)));
    req = 2'($urandom_range(0, 3));
    k = 0;
    budget = 0;
    while (k < 8 && budget < 200) begin
      v = (gmode == 0) ? 1'b1 : (gmode == 1) ? (budget[0] == 1'b0) : 1'($urandom_range(0, 1));
      s0_re = 16'($urandom); s0_im = 16'($urandom);
      s1_re = 16'($urandom); s1_im = 16'($urandom);
      if (id) begin s1_re = smp[k][31:16]; s1_im = smp[k][15:0]; end
      else    begin s0_re = smp[k][31:16]; s0_im = smp[k][15:0]; end
      s_valid = v ? onehot(id) : 2'b00;
      s_valid[~id] = 1'($urandom_range(0, 1));
      chk("s_ready_load", 64'(s_ready), 64'(onehot(id)));
      if (v) begin
        k++;
        if (k == 8) last_acc = cyc;
      end
      tick();
      finish = ($urandom_range(0, 5) == 0);
      budget++;
    end
    if (k < 8) fail_now("load_budget");
    s_valid = '0;
    req = '0;
    finish = 1'b0;
    chk("s_ready_drop", 64'(s_ready), 64'(0));
    if (rst_at > 0) begin
      wait_until(last_acc + rst_at);
      do_reset();
      return;
    end
    wait_until(last_acc + 5);
    finish = 1'b1;
    if (fd < 0) begin
      wait_until(last_acc + 10);
      r.id = p_id; r.c0r = p_c0r; r.c0i = p_c0i; r.c1r = p_c1r; r.c1i = p_c1i;
      r.err = 1'b1; r.cyc = last_acc + 10 + int'(TMO);
      p_err = 1'b1;
      exp_out.push_back(r);
    end else begin
      wait_until(last_acc + 10 + fd);
      for (int i = 0; i < 4; i++) c[i] = {$urandom, $urandom};
      finish = 1'b1;
      a_col0_r = c[0]; a_col0_i = c[1]; a_col1_r = c[2]; a_col1_i = c[3];
      r.id = id; r.c0r = c[0]; r.c0i = c[1]; r.c1r = c[2]; r.c1i = c[3];
      r.err = p_err; r.cyc = last_acc + 11 + fd;
      p_id = id; p_c0r = c[0]; p_c0i = c[1]; p_c1r = c[2]; p_c1i = c[3];
      exp_out.push_back(r);
    end
    budget = 0;
    while (exp_out.size() != 0 && budget < 300) begin
      tick();
      budget++;
    end
    if (exp_out.size() != 0) begin
      fail_now("out_handshake");
      exp_out.delete();
    end
    rr_last = id;
  endtask

  // Stream monitor: start timing, 8 gapless samples, idle zeros, grant sanity
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && start) begin
        chk("start_time", 64'(cyc), 64'(last_acc + 1));
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (!rst_n) break;
          if (exp_stream.size() == 0) fail_now("stream_extra");
          else begin
            e = exp_stream.pop_front();
            chk("stream", 64'({sdr, sdi}), 64'(e));
            chk("start_pulse", 64'(start), 64'(0));
          end
        end
      end else if (rst_n) begin
        chk("sd_idle", 64'({sdr, sdi}), 64'(0));
      end
      if (rst_n) begin
        chk("gnt_onehot", 64'(gnt == 2'b11), 64'(0));
        chk("s_ready_granted", 64'(s_ready & ~gnt), 64'(0));
      end
    end
  end

  // Result monitor: latency, stability under backpressure, handshake return to idle
  initial begin
    res_t r;
    int   hold;
    bit   first;
    first = 1'b1;
    hold = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_ready = 1'b0;
        first = 1'b1;
        continue;
      end
      if (out_valid) begin
        if (exp_out.size() == 0) begin
          fail_now("out_expected");
          out_ready = 1'b1;
        end else begin
          r = exp_out[0];
          if (first) begin
            chk("out_latency", 64'(cyc), 64'(r.cyc));
            hold = bp_cycles;
            first = 1'b0;
            m_err = r.err;
          end
          chk("out_id", 64'(out_id), 64'(r.id));
          chk("col0_r", col0_r, r.c0r);
          chk("col0_i", col0_i, r.c0i);
          chk("col1_r", col1_r, r.c1r);
          chk("col1_i", col1_i, r.c1i);
          chk("out_err", 64'(err), 64'(r.err));
          chk("out_gnt", 64'(gnt), 64'(onehot(rr_next(r))));
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
          end else begin
            out_ready = ($urandom_range(0, 3) != 0);
          end
          if (out_ready) begin
            @(negedge clk);
            if (rst_n) begin
              void'(exp_out.pop_front());
              chk("idle_gnt", 64'(gnt), 64'(0));
              chk("idle_valid", 64'(out_valid), 64'(0));
            end
            first = 1'b1;
            out_ready = 1'b0;
          end
        end
      end else begin
        chk("err_sticky", 64'(err), 64'(m_err));
      end
    end
  end

  // Granted index of the job being presented (timeout results keep the old out_id)
  logic cur_id = 1'b0;
  function automatic logic rr_next(input res_t r);
    return r.err && (r.id != cur_id) ? cur_id : (r.cyc >= 0 ? cur_id : r.id);
  endfunction

  initial begin
    rst_n = 1'b0;
    req = '0; s_valid = '0; finish = 1'b0;
    s0_re = '0; s0_im = '0; s1_re = '0; s1_im = '0;
    a_col0_r = '0; a_col0_i = '0; a_col1_r = '0; a_col1_i = '0;
    #3 check_reset_outputs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    cur_id = 1'b0; run_job(2'b01, 0, 0, 0, 1'b1, 0);
    do_reset();
    cur_id = 1'b0; run_job(2'b11, 0, 1, 0, 1'b0, 0);
    cur_id = 1'b1; run_job(2'b11, 0, 0, 0, 1'b0, 0);
    cur_id = 1'b0; run_job(2'b11, 1, 3, 0, 1'b0, 0);
    cur_id = 1'b1; run_job(2'b10, 2, 0, 5, 1'b0, 0);
    cur_id = 1'b0; run_job(2'b01, 0, -1, 2, 1'b0, 0);
    cur_id = 1'b1; run_job(2'b11, 2, TMO - 1, 0, 1'b0, 0);
    cur_id = 1'b0; run_job(2'b11, 0, 0, 0, 1'b0, 4);
    cur_id = 1'b1; run_job(2'b10, 0, 2, 1, 1'b0, 0);
    for (int j = 0; j < 12; j++) begin
      logic [1:0] rq;
      int         fd;
      rq = 2'($urandom_range(1, 3));
      cur_id = (rq == 2'b11) ? ~rr_last : rq[1];
      fd = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
      run_job(rq, int'($urandom_range(0, 2)), fd, int'($urandom_range(0, 3)), 1'b0, 0);
    end
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required one (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/col_gen_sched.md
COL_GEN_SCHED -- requirements
Module: col_gen_sched

Interface
REQ-001 Parameter TMO, default 8: max cycles WAIT may last before the error flag sets.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 req  input  2  per-requester request for one 8-sample column job.
REQ-005 gnt  output  2  one-hot grant; 00 when idle.
REQ-006 s_valid  input  2  per-requester sample valid.
REQ-007 s_ready  output  2  per-requester sample ready; only the granted bit may be 1.
REQ-008 s0_re, s0_im, s1_re, s1_im  input  16 each  sample real/imag from requester 0/1.
REQ-009 start  output  1  one-cycle start pulse to the column assembler.
REQ-010 sdr, sdi  output  16 each  sample stream to the assembler.
REQ-011 finish  input  1  assembler done pulse.
REQ-012 a_col0_r, a_col0_i, a_col1_r, a_col1_i  input  64 each  assembler column outputs; valid only while finish=1.
REQ-013 out_valid  output  1  captured job result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_id  output  1  requester index of the result.
REQ-016 col0_r, col0_i, col1_r, col1_i  output  64 each  captured columns.
REQ-017 err  output  1  sticky finish-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, START, STREAM, WAIT, OUT.
REQ-019 IDLE: any req bit set -> grant by round-robin (priority to the requester not last served; requester 0 after reset), go LOAD next cycle with gnt asserted.
REQ-020 gnt SHALL stay constant from grant until OUT handshake; req deassertion after grant SHALL be ignored.
REQ-021 LOAD: s_ready[gnt]=1; each cycle with s_valid&s_ready stores the selected sample into 8-entry buffer slot cnt, cnt 3-bit increments; gaps in s_valid allowed.
REQ-022 Sample order: slot k even -> column 0, k odd -> column 1, row index k/2.
REQ-023 Accept of slot 7 -> START next cycle; s_ready drops to 0 the cycle after that accept.
REQ-024 START: start=1 for exactly one cycle, sdr=sdi=0.
REQ-025 STREAM: exactly 8 consecutive cycles, sdr/sdi = buffer slot 0..7 in order, no gaps; then WAIT.
REQ-026 WAIT: on finish=1 capture all four a_col* into col* registers, out_id=granted index, go OUT; a_col* SHALL never be sampled when finish=0.
REQ-027 WAIT timeout: TMO cycles without finish -> err=1, capture nothing, go OUT with previous col* contents.
REQ-028 Latency: slot-7 accept in cycle L -> start in L+1, slot 0 on sdr in L+2, slot 7 in L+9, finish expected L+10, out_valid from L+11.
REQ-029 OUT: out_valid=1; col*/out_id stable while out_valid & !out_ready.
REQ-030 out_valid & out_ready -> IDLE, gnt=00, round-robin pointer updated; new arbitration occurs in IDLE the following cycle (never same cycle).
REQ-031 finish outside WAIT SHALL be ignored.
REQ-032 sdr/sdi SHALL be 0 outside STREAM; start 0 outside START.

Reset
REQ-033 rst=0: state IDLE, cnt=0, gnt=00, s_ready=00, start=0, sdr=sdi=0, out_valid=0, out_id=0, col*=0, err=0, round-robin priority requester 0.
REQ-034 Reset mid-job SHALL abandon the job with no output; err clears only by reset.

Verification
REQ-035 Single job: req=01, samples 0x0001..0x0008 (im = re+0x100), no gaps -> start 1 cycle after slot 7, sdr 1..8 consecutive, result out_id=0, out_valid at L+11.
REQ-036 Contention: req=11 from reset twice -> first grant 01, second 10; gnt never 11.
REQ-037 Gapped input: s_valid toggling every cycle -> 8 samples stored, STREAM still 8 gapless cycles.
REQ-038 Backpressure: out_ready=0 for 5 cycles -> col*/out_id unchanged, no new gnt until handshake.
REQ-039 Timeout: finish held 0 -> err=1 exactly TMO cycles into WAIT, out_valid=1, col* = previous values.
REQ-040 Reset during STREAM -> all outputs to REQ-033 values immediately; next req served normally.
